rx_bit_timer: RTL and testbench

RX_BIT_TIMER -- requirements
Module: rx_bit_timer

---
 rtl/usb_timing_pkg.sv | 21 ++
 rtl/rx_tick_gen.sv | 37 +++
 rtl/rx_bit_timer.sv | 59 +++++
 tb/tb_rx_bit_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/usb_timing_pkg.sv
// Bit-timing constants and helpers shared by the USB receive and transmit timers.
// Three bits take 25 clocks, split into phases of 8, 8 and 9 clocks.
package usb_timing_pkg;

   localparam int BIT_PERIOD_SHORT = 8;
   localparam int BIT_PERIOD_LONG  = 9;
   localparam int NUM_PHASES       = 3;
   localparam int TICK_W           = 4;

   typedef logic [TICK_W-1:0] tick_t;
   typedef logic [1:0]        phase_t;

   localparam phase_t LAST_PHASE = phase_t'(NUM_PHASES - 1);

   // The last phase of the three-bit pattern carries the extra clock.
   function automatic tick_t phase_last_tick(input phase_t phase);
      return (phase == LAST_PHASE) ? tick_t'(BIT_PERIOD_LONG - 1)
                                   : tick_t'(BIT_PERIOD_SHORT - 1);
   endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Receive bit clock: per-bit tick counter with 8/8/9 phase pattern, edge resync
// and a zero-latency sample strobe at bit centre.
module rx_tick_gen
   import usb_timing_pkg::*;
#(
   parameter int SAMPLE_TICK = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   enable_timer,
   input  logic   clear_timer,
   input  logic   d_edge,
   output tick_t  tick,
   output phase_t phase,
   output logic   strobe
);

   // An edge restarts the bit with the edge cycle as tick 0, so the next tick is 1.
   always_ff @(posedge clk) begin
      if (rst || clear_timer) begin
         tick  <= '0;
         phase <= '0;
      end else if (enable_timer) begin
         if (d_edge) begin
            tick <= tick_t'(1);
         end else if (tick == phase_last_tick(phase)) begin
            tick  <= '0;
            phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

   assign strobe = enable_timer && !clear_timer && !rst && (tick == tick_t'(SAMPLE_TICK));

endmodule

// File: rtl/rx_bit_timer.sv
// Receive bit timer: samples at bit centre, counts unstuffed data bits and
// pulses byte_received the cycle after the last data bit of a byte.
module rx_bit_timer
   import usb_timing_pkg::*;
#(
   parameter int SAMPLE_TICK   = 4,
   parameter int BITS_PER_BYTE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_timer,
   input  logic       clear_timer,
   input  logic       d_edge,
   input  logic       stuff_bit,
   output logic       sample_strobe,
   output logic [3:0] bit_count,
   output logic       byte_received
);

   localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

   tick_t  cur_tick;
   phase_t cur_phase;
   logic   unused_state;

   rx_tick_gen #(
      .SAMPLE_TICK (SAMPLE_TICK)
   ) u_tick_gen (
      .clk          (clk),
      .rst          (rst),
      .enable_timer (enable_timer),
      .clear_timer  (clear_timer),
      .d_edge       (d_edge),
      .tick         (cur_tick),
      .phase        (cur_phase),
      .strobe       (sample_strobe)
   );

   // Tick and phase are only of interest for debug visibility here.
   assign unused_state = ^{cur_tick, cur_phase};

   always_ff @(posedge clk) begin
      if (rst || clear_timer) begin
         bit_count     <= '0;
         byte_received <= 1'b0;
      end else begin
         byte_received <= 1'b0;
         if (sample_strobe && !stuff_bit) begin
            if (bit_count == LAST_BIT) begin
               bit_count     <= '0;
               byte_received <= 1'b1;
            end else begin
               bit_count <= bit_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed timing scenarios plus random
// stimulus compared every cycle against a behavioural bit-timing model.
module tb_rx_bit_timer;

   localparam int SAMPLE_TICK   = 4;
   localparam int BITS_PER_BYTE = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_timer;
   logic       clear_timer;
   logic       d_edge;
   logic       stuff_bit;
   logic       sample_strobe;
   logic [3:0] bit_count;
   logic       byte_received;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int strobe_q[$];
   int byte_q[$];
   int want_q[$];
   int last_tick, last_phase, last_count;

   // Model: position inside the current bit, which of the 8/8/9 bits we are in,
   // data bits so far, and whether a byte completion pulse is due.
   int periods[3] = '{8, 8, 9};
   int m_pos, m_phase, m_count;
   bit m_byte;

   rx_bit_timer #(
      .SAMPLE_TICK   (SAMPLE_TICK),
      .BITS_PER_BYTE (BITS_PER_BYTE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable_timer  (enable_timer),
      .clear_timer   (clear_timer),
      .d_edge        (d_edge),
      .stuff_bit     (stuff_bit),
      .sample_strobe (sample_strobe),
      .bit_count     (bit_count),
      .byte_received (byte_received)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkList(input string tag, input int got[$], input int want[$]);
      checkOutput({tag, "_count"}, got.size(), want.size());
      for (int i = 0; i < want.size(); i++)
         checkOutput($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, want[i]);
   endtask

   // Drive one cycle, compare outputs with the model mid-cycle, then advance the model.
   task automatic applyStimulus(input bit r, input bit en, input bit clr, input bit ed, input bit st);
      bit exp_strobe;
      rst = r; enable_timer = en; clear_timer = clr; d_edge = ed; stuff_bit = st;
      @(negedge clk);
      exp_strobe = !r && en && !clr && (m_pos == SAMPLE_TICK);
      checkOutput($sformatf("strobe@%0d", cyc), int'(sample_strobe), int'(exp_strobe));
      checkOutput($sformatf("bit_count@%0d", cyc), int'(bit_count), m_count);
      checkOutput($sformatf("byte_received@%0d", cyc), int'(byte_received), int'(m_byte));
      last_tick  = int'(dut.u_tick_gen.tick);
      last_phase = int'(dut.u_tick_gen.phase);
      last_count = int'(bit_count);
      if (sample_strobe) strobe_q.push_back(cyc);
      if (byte_received) byte_q.push_back(cyc);
      if (r || clr) begin
         m_pos = 0; m_phase = 0; m_count = 0; m_byte = 0;
      end else begin
         m_byte = 0;
         if (en) begin
            if (ed) m_pos = 1;
            else if (m_pos + 1 == periods[m_phase]) begin
               m_pos = 0;
               m_phase = (m_phase + 1) % 3;
            end else m_pos++;
         end
         if (exp_strobe && !st) begin
            m_count = (m_count + 1) % BITS_PER_BYTE;
            m_byte = (m_count == 0);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic startScenario();
      applyStimulus(0, 0, 1, 0, 0);
      cyc = 0;
      strobe_q.delete();
      byte_q.delete();
   endtask

   initial begin
      rst = 1'b1; enable_timer = 1'b0; clear_timer = 1'b0; d_edge = 1'b0; stuff_bit = 1'b0;
      @(posedge clk);
      #1;
      m_pos = 0; m_phase = 0; m_count = 0; m_byte = 0;
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("reset_bit_count", int'(bit_count), 0);
      checkOutput("reset_byte_received", int'(byte_received), 0);
      checkOutput("reset_tick", int'(dut.u_tick_gen.tick), 0);

      // Free-running byte with no edges.
      startScenario();
      for (int c = 0; c <= 63; c++) begin
         applyStimulus(0, 1, 0, 0, 0);
         if (c == 63) checkOutput("free_count63", last_count, 0);
      end
      want_q = '{4, 12, 20, 29, 37, 45, 54, 62};
      checkList("free_strobes", strobe_q, want_q);
      want_q = '{63};
      checkList("free_byte", byte_q, want_q);

      // Edge resynchronisation.
      startScenario();
      for (int c = 0; c <= 11; c++) begin
         applyStimulus(0, 1, 0, c == 6, 0);
         if (c == 7) checkOutput("resync_tick7", last_tick, 1);
      end
      want_q = '{4, 10};
      checkList("resync_strobes", strobe_q, want_q);

      // Stuffed bit on the third strobe.
      startScenario();
      for (int c = 0; c <= 72; c++) begin
         applyStimulus(0, 1, 0, 0, c == 20);
         if (c == 21) checkOutput("stuff_count21", last_count, 2);
      end
      want_q = '{71};
      checkList("stuff_byte", byte_q, want_q);

      // Freeze after the first strobe.
      startScenario();
      for (int c = 0; c <= 23; c++) begin
         applyStimulus(0, !(c >= 5 && c <= 14), 0, 0, 0);
         if (c == 15) checkOutput("freeze_count15", last_count, 1);
      end
      want_q = '{4, 22};
      checkList("freeze_strobes", strobe_q, want_q);

      // Clear mid-byte, then the same with reset.
      for (int k = 0; k < 2; k++) begin
         startScenario();
         for (int c = 0; c <= 46; c++) begin
            applyStimulus((k == 1) && (c == 40), 1, (k == 0) && (c == 40), 0, 0);
            if (c == 40) checkOutput($sformatf("midbyte%0d_count40", k), last_count, 5);
            if (c == 41) checkOutput($sformatf("midbyte%0d_count41", k), last_count, 0);
         end
         want_q = '{4, 12, 20, 29, 37, 45};
         checkList($sformatf("midbyte%0d_strobes", k), strobe_q, want_q);
      end

      // Coincidences: edge on last tick of long bit, edge on sample tick, edge with clear.
      startScenario();
      for (int c = 0; c <= 32; c++) begin
         applyStimulus(0, 1, c == 31, (c == 24) || (c == 28) || (c == 31), 0);
         if (c == 25) begin
            checkOutput("coin_tick25", last_tick, 1);
            checkOutput("coin_phase25", last_phase, 2);
         end
         if (c == 29) checkOutput("coin_tick29", last_tick, 1);
         if (c == 32) begin
            checkOutput("coin_clear_tick", last_tick, 0);
            checkOutput("coin_clear_phase", last_phase, 0);
         end
      end
      want_q = '{4, 12, 20, 28};
      checkList("coin_strobes", strobe_q, want_q);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                       $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 6) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
